// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and constants for the LC-3 memory sequencer
package lc3_mem_pkg;

  localparam logic [15:0] MMIO_ADDR   = 16'hFFFF;
  localparam int          SRAM_ADDR_W = 20;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACT,
    RD_DONE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    WR_DONE
  } mem_state_e;

endpackage

// File: rtl/lc3_mem_sequencer_if.sv
// rtl/lc3_mem_sequencer_if.sv - asynchronous SRAM pin bundle between sequencer and SRAM
interface lc3_mem_sequencer_if;
  import lc3_mem_pkg::*;

  logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
  logic                   SRAM_CE_N;
  logic                   SRAM_OE_N;
  logic                   SRAM_WE_N;
  logic                   SRAM_UB_N;
  logic                   SRAM_LB_N;
  logic [15:0]            SRAM_DQ_in;
  logic [15:0]            SRAM_DQ_out;
  logic                   SRAM_DQ_oe;

  modport master (
    output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
    output SRAM_DQ_out, SRAM_DQ_oe,
    input  SRAM_DQ_in
  );

  modport slave (
    input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
    input  SRAM_DQ_out, SRAM_DQ_oe,
    output SRAM_DQ_in
  );

endinterface

// File: rtl/lc3_mmio_regs.sv
// rtl/lc3_mmio_regs.sv - hex display register and switch read select for the 16'hFFFF I/O port
module lc3_mmio_regs (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        hex_we,
  input  logic [15:0] hex_wdata,
  input  logic [15:0] Switches,
  input  logic        sel_switches,
  input  logic [15:0] sram_rdata,
  output logic [15:0] rd_data,
  output logic [15:0] Hex_Data
);

  logic [15:0] hex_data_q, hex_data_d;

  always_comb begin
    hex_data_d = hex_data_q;
    if (hex_we) hex_data_d = hex_wdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) hex_data_q <= 16'h0000;
    else       hex_data_q <= hex_data_d;
  end

  assign Hex_Data = hex_data_q;
  assign rd_data  = sel_switches ? Switches : sram_rdata;

endmodule

// File: rtl/lc3_mem_sequencer.sv
// rtl/lc3_mem_sequencer.sv - LC-3 request-level to SRAM strobe sequencer
// Define LC3_MMIO_EN to map switches/hex display at 16'hFFFF instead of SRAM.
module lc3_mem_sequencer
  import lc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Mem_OE,
  input  logic                Mem_WE,
  input  logic [15:0]         ADDR,
  input  logic [15:0]         Data_from_CPU,
  output logic [15:0]         Data_to_CPU,
  output logic                Mem_Ready,
  input  logic [15:0]         Switches,
  output logic [15:0]         Hex_Data,
  lc3_mem_sequencer_if.master sram
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic [15:0] data_to_cpu_q, data_to_cpu_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, bl_n_q, bl_n_d;
  logic        dq_oe_q, dq_oe_d, ready_q, ready_d;
  logic        accept, rd_last, acc_mmio;
  logic [15:0] rd_data;

  assign accept  = (state_q == IDLE) && (Mem_OE || Mem_WE);
  assign rd_last = (state_q == RD_ACT) && (cnt_q == 4'd0);

`ifdef LC3_MMIO_EN
  logic mmio_q, mmio_d;

  // The I/O-port flag follows ADDR while idle and freezes for the access.
  assign acc_mmio = (state_q == IDLE) ? (ADDR == MMIO_ADDR) : mmio_q;
  assign mmio_d   = acc_mmio;

  always_ff @(posedge Clk) begin
    if (Reset) mmio_q <= 1'b0;
    else       mmio_q <= mmio_d;
  end

  lc3_mmio_regs u_mmio_regs (
    .Clk          (Clk),
    .Reset        (Reset),
    .hex_we       ((state_q == WR_SETUP) && mmio_q),
    .hex_wdata    (Data_from_CPU),
    .Switches     (Switches),
    .sel_switches (mmio_q),
    .sram_rdata   (sram.SRAM_DQ_in),
    .rd_data      (rd_data),
    .Hex_Data     (Hex_Data)
  );
`else
  logic unused_switches;

  assign acc_mmio        = 1'b0;
  assign rd_data         = sram.SRAM_DQ_in;
  assign Hex_Data        = 16'h0000;
  assign unused_switches = ^Switches;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Mem_WE) begin
          state_d = WR_SETUP;
        end else if (Mem_OE) begin
          state_d = RD_ACT;
          cnt_d   = CNT_LOAD;
        end
      end
      RD_ACT: begin
        if (cnt_q == 4'd0) state_d = RD_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RD_DONE:  if (!Mem_OE) state_d = IDLE;
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_LOAD;
      end
      WR_PULSE: begin
        if (cnt_q == 4'd0) state_d = WR_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WR_HOLD:  state_d = WR_DONE;
      WR_DONE:  if (!Mem_WE) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    bl_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    ready_d = 1'b0;
    unique case (state_d)
      RD_ACT: begin
        ce_n_d = acc_mmio;
        oe_n_d = 1'b0;
        bl_n_d = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_d  = acc_mmio;
        bl_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      WR_PULSE: begin
        ce_n_d  = acc_mmio;
        we_n_d  = 1'b0;
        bl_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      RD_DONE, WR_DONE: ready_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    addr_d        = accept ? ADDR : addr_q;
    dq_out_d      = ((accept && Mem_WE) || (state_q == WR_SETUP)) ? Data_from_CPU : dq_out_q;
    data_to_cpu_d = rd_last ? rd_data : data_to_cpu_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      addr_q        <= 16'h0000;
      dq_out_q      <= 16'h0000;
      data_to_cpu_q <= 16'h0000;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      bl_n_q        <= 1'b1;
      dq_oe_q       <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      dq_out_q      <= dq_out_d;
      data_to_cpu_q <= data_to_cpu_d;
      ce_n_q        <= ce_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      bl_n_q        <= bl_n_d;
      dq_oe_q       <= dq_oe_d;
      ready_q       <= ready_d;
    end
  end

  assign sram.SRAM_ADDR   = {{(SRAM_ADDR_W-16){1'b0}}, addr_q};
  assign sram.SRAM_CE_N   = ce_n_q;
  assign sram.SRAM_OE_N   = oe_n_q;
  assign sram.SRAM_WE_N   = we_n_q;
  assign sram.SRAM_UB_N   = bl_n_q;
  assign sram.SRAM_LB_N   = bl_n_q;
  assign sram.SRAM_DQ_out = dq_out_q;
  assign sram.SRAM_DQ_oe  = dq_oe_q;
  assign Data_to_CPU      = data_to_cpu_q;
  assign Mem_Ready        = ready_q;

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// tb/tb_lc3_mem_sequencer.sv - directed self-checking bench for lc3_mem_sequencer
// Inputs change and outputs are sampled on the falling edge of Clk.
module tb_lc3_mem_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_OE, Mem_WE;
  logic [15:0] ADDR, Data_from_CPU, Switches;
  logic [15:0] Data_to_CPU, Hex_Data;
  logic        Mem_Ready;

  logic [15:0] mem [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr, pre_data;

  int n_cmp = 0;
  int n_bad = 0;

  lc3_mem_sequencer_if sram ();

  lc3_mem_sequencer #(.WAIT_CYCLES(2)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Data_to_CPU   (Data_to_CPU),
    .Mem_Ready     (Mem_Ready),
    .Switches      (Switches),
    .Hex_Data      (Hex_Data),
    .sram          (sram)
  );

  always #5 Clk = ~Clk;

  // SRAM model: writes while CE and WE are low; reads return DEAD unless CE and OE are low.
  always @(posedge Clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!sram.SRAM_CE_N && !sram.SRAM_WE_N) mem[sram.SRAM_ADDR[15:0]] <= sram.SRAM_DQ_out;
  end

  assign sram.SRAM_DQ_in = (!sram.SRAM_CE_N && !sram.SRAM_OE_N) ? mem[sram.SRAM_ADDR[15:0]] : 16'hDEAD;

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({sram.SRAM_CE_N, sram.SRAM_OE_N, sram.SRAM_WE_N, sram.SRAM_UB_N, sram.SRAM_LB_N} !== 5'b11111) begin
        n_bad++; $display("FAIL reset_strobes[%0d]: got %b want 11111", k,
          {sram.SRAM_CE_N, sram.SRAM_OE_N, sram.SRAM_WE_N, sram.SRAM_UB_N, sram.SRAM_LB_N});
      end
      n_cmp++;
      if ({sram.SRAM_DQ_oe, Mem_Ready} !== 2'b00) begin
        n_bad++; $display("FAIL reset_oe_ready[%0d]: got %b want 00", k, {sram.SRAM_DQ_oe, Mem_Ready});
      end
      n_cmp++;
      if ({Data_to_CPU, sram.SRAM_DQ_out, Hex_Data} !== 48'h0) begin
        n_bad++; $display("FAIL reset_data[%0d]: got %h want 0", k, {Data_to_CPU, sram.SRAM_DQ_out, Hex_Data});
      end
      n_cmp++;
      if (sram.SRAM_ADDR !== 20'h00000) begin
        n_bad++; $display("FAIL reset_addr[%0d]: got %h want 00000", k, sram.SRAM_ADDR);
      end
      Reset = 1'b0;
      step();
    end
  endtask

  task automatic test_read();
    int oe_low = 0;
    preload(16'h0040, 16'h1234);
    ADDR   = 16'h0040;
    Mem_OE = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (sram.SRAM_OE_N === 1'b0) oe_low++;
      if (i == 1) begin
        n_cmp++;
        if (sram.SRAM_ADDR !== 20'h00040) begin
          n_bad++; $display("FAIL rd_addr: got %h want 00040", sram.SRAM_ADDR);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (Data_to_CPU !== 16'h1234) begin
          n_bad++; $display("FAIL rd_data: got %h want 1234", Data_to_CPU);
        end
        n_cmp++;
        if (Mem_Ready !== 1'b1) begin
          n_bad++; $display("FAIL rd_ready: got %b want 1", Mem_Ready);
        end
      end
      if (i == 4) Mem_OE = 1'b0;
      if (i == 5) begin
        n_cmp++;
        if (Mem_Ready !== 1'b0) begin
          n_bad++; $display("FAIL rd_ready_idle: got %b want 0", Mem_Ready);
        end
      end
    end
    n_cmp++;
    if (oe_low != 2) begin
      n_bad++; $display("FAIL rd_oe_cycles: got %0d want 2", oe_low);
    end
  endtask

  task automatic test_write();
    int we_low = 0;
    int oe_low = 0;
    int dq_bad = 0;
    ADDR          = 16'h0100;
    Data_from_CPU = 16'hBEEF;
    Mem_WE        = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (sram.SRAM_WE_N === 1'b0) we_low++;
      if (sram.SRAM_OE_N === 1'b0) oe_low++;
      if (i >= 1 && i <= 4 && (sram.SRAM_DQ_oe !== 1'b1 || sram.SRAM_CE_N !== 1'b0)) dq_bad++;
      if (i >= 2 && i <= 4 && sram.SRAM_DQ_out !== 16'hBEEF) dq_bad++;
      if (i == 5) begin
        Mem_WE = 1'b0;
        n_cmp++;
        if ({Mem_Ready, sram.SRAM_DQ_oe, sram.SRAM_CE_N} !== 3'b101) begin
          n_bad++; $display("FAIL wr_done: got %b want 101", {Mem_Ready, sram.SRAM_DQ_oe, sram.SRAM_CE_N});
        end
      end
      if (i == 6) begin
        n_cmp++;
        if (Mem_Ready !== 1'b0) begin
          n_bad++; $display("FAIL wr_done_len: got %b want 0", Mem_Ready);
        end
      end
    end
    n_cmp++;
    if (we_low != 2) begin
      n_bad++; $display("FAIL wr_we_cycles: got %0d want 2", we_low);
    end
    n_cmp++;
    if (dq_bad != 0) begin
      n_bad++; $display("FAIL wr_dq_window: got %0d bad cycles want 0", dq_bad);
    end
    n_cmp++;
    if (mem[16'h0100] !== 16'hBEEF) begin
      n_bad++; $display("FAIL wr_readback: got %h want beef", mem[16'h0100]);
    end
    n_cmp++;
    if (oe_low != 0) begin
      n_bad++; $display("FAIL wr_oe_cycles: got %0d want 0", oe_low);
    end
  endtask

  task automatic test_simultaneous();
    int we_low = 0;
    int oe_low = 0;
    ADDR          = 16'h0200;
    Data_from_CPU = 16'h5A5A;
    Mem_OE        = 1'b1;
    Mem_WE        = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (sram.SRAM_WE_N === 1'b0) we_low++;
      if (sram.SRAM_OE_N === 1'b0) oe_low++;
      if (i == 5) begin
        Mem_OE = 1'b0;
        Mem_WE = 1'b0;
      end
    end
    n_cmp++;
    if (oe_low != 0 || we_low != 2) begin
      n_bad++; $display("FAIL sim_strobes: got oe_low=%0d we_low=%0d want 0 and 2", oe_low, we_low);
    end
    n_cmp++;
    if (mem[16'h0200] !== 16'h5A5A) begin
      n_bad++; $display("FAIL sim_readback: got %h want 5a5a", mem[16'h0200]);
    end
  endtask

  task automatic test_early_drop();
    preload(16'h0041, 16'hCAFE);
    ADDR   = 16'h0041;
    Mem_OE = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) Mem_OE = 1'b0;
      if (i == 3) begin
        n_cmp++;
        if ({Mem_Ready, Data_to_CPU} !== {1'b1, 16'hCAFE}) begin
          n_bad++; $display("FAIL drop_done: got %b/%h want 1/cafe", Mem_Ready, Data_to_CPU);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (Mem_Ready !== 1'b0) begin
          n_bad++; $display("FAIL drop_done_len: got %b want 0", Mem_Ready);
        end
        ADDR   = 16'h0040;
        Mem_OE = 1'b1;
      end
      if (i == 5) begin
        Mem_OE = 1'b0;
        n_cmp++;
        if (sram.SRAM_OE_N !== 1'b0) begin
          n_bad++; $display("FAIL drop_next_accept: got %b want 0", sram.SRAM_OE_N);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (Data_to_CPU !== 16'h1234) begin
          n_bad++; $display("FAIL drop_next_data: got %h want 1234", Data_to_CPU);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    ADDR          = 16'h0300;
    Data_from_CPU = 16'h7777;
    Mem_WE        = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 5) Mem_WE = 1'b0;
      if (i == 6) Mem_OE = 1'b1;
      if (i == 7) begin
        n_cmp++;
        if (sram.SRAM_OE_N !== 1'b0) begin
          n_bad++; $display("FAIL b2b_accept: got %b want 0", sram.SRAM_OE_N);
        end
      end
      if (i == 9) begin
        Mem_OE = 1'b0;
        n_cmp++;
        if (Data_to_CPU !== 16'h7777) begin
          n_bad++; $display("FAIL b2b_data: got %h want 7777", Data_to_CPU);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    ADDR          = 16'h0400;
    Data_from_CPU = 16'h1111;
    Mem_WE        = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 2) Reset = 1'b1;
      if (i == 3) begin
        n_cmp++;
        if ({sram.SRAM_WE_N, sram.SRAM_CE_N, sram.SRAM_DQ_oe, Mem_Ready} !== 4'b1100) begin
          n_bad++; $display("FAIL rst_mid: got %b want 1100",
            {sram.SRAM_WE_N, sram.SRAM_CE_N, sram.SRAM_DQ_oe, Mem_Ready});
        end
        Reset  = 1'b0;
        Mem_WE = 1'b0;
        ADDR   = 16'h0040;
        Mem_OE = 1'b1;
      end
      if (i == 4) begin
        n_cmp++;
        if (sram.SRAM_OE_N !== 1'b0) begin
          n_bad++; $display("FAIL rst_mid_idle: got %b want 0", sram.SRAM_OE_N);
        end
      end
    end
    for (int i = 5; i <= 8; i++) begin
      step();
      if (i == 6) Mem_OE = 1'b0;
    end
  endtask

`ifdef LC3_MMIO_EN
  task automatic test_mmio();
    int ce_low = 0;
    ADDR   = 16'hFFFF;
    Mem_OE = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (sram.SRAM_CE_N !== 1'b1) ce_low++;
      if (i == 3) begin
        n_cmp++;
        if (Data_to_CPU !== 16'h00A5) begin
          n_bad++; $display("FAIL mmio_rd: got %h want 00a5", Data_to_CPU);
        end
      end
      if (i == 4) Mem_OE = 1'b0;
    end
    Data_from_CPU = 16'h0042;
    Mem_WE        = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (sram.SRAM_CE_N !== 1'b1) ce_low++;
      if (i == 2) begin
        n_cmp++;
        if (Hex_Data !== 16'h0042) begin
          n_bad++; $display("FAIL mmio_hex: got %h want 0042", Hex_Data);
        end
      end
      if (i == 5) Mem_WE = 1'b0;
    end
    n_cmp++;
    if (ce_low != 0) begin
      n_bad++; $display("FAIL mmio_ce: got %0d low cycles want 0", ce_low);
    end
  endtask
`else
  task automatic test_no_mmio();
    ADDR          = 16'hFFFF;
    Data_from_CPU = 16'h0042;
    Mem_WE        = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 2) begin
        n_cmp++;
        if (sram.SRAM_CE_N !== 1'b0) begin
          n_bad++; $display("FAIL nommio_ce: got %b want 0", sram.SRAM_CE_N);
        end
      end
      if (i == 5) Mem_WE = 1'b0;
    end
    n_cmp++;
    if (Hex_Data !== 16'h0000) begin
      n_bad++; $display("FAIL nommio_hex: got %h want 0000", Hex_Data);
    end
    n_cmp++;
    if (mem[16'hFFFF] !== 16'h0042) begin
      n_bad++; $display("FAIL nommio_sram: got %h want 0042", mem[16'hFFFF]);
    end
  endtask
`endif

  initial begin
    Reset         = 1'b1;
    Mem_OE        = 1'b0;
    Mem_WE        = 1'b0;
    ADDR          = 16'h0000;
    Data_from_CPU = 16'h0000;
    Switches      = 16'h00A5;
    pre_we        = 1'b0;
    pre_addr      = 16'h0000;
    pre_data      = 16'h0000;
    step();
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_early_drop();
    test_back_to_back();
    test_reset_mid();
`ifdef LC3_MMIO_EN
    test_mmio();
`else
    test_no_mmio();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
